ks_serial_subtractor: RTL
=========================

// Module: ks_serial_subtractor
// PURPOSE
//  Multi-cycle unsigned/two's-complement subtractor, the inverse operation of the registered
//  Kogge-Stone adder top. Computes diff = a - b - bin over W = 4*NIBBLES bits, one nibble
//  per cycle, through a single 4-bit Kogge-Stone core with the carry registered between nibbles.
//  Valid/ready handshakes on both sides; sits between an operand source and a result consumer.
// PARAMETERS
//  NIBBLES   4   number of 4-bit slices; operand width W = 4*NIBBLES (legal range 1..16)
// PORTS
//  clk         in   1   single clock; all state changes on the rising edge
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   operands a_in/b_in/bin_in valid
//  in_ready    out  1   block can accept operands
//  a_in        in   W   minuend
//  b_in        in   W   subtrahend
//  bin_in      in   1   borrow-in
//  out_valid   out  1   result outputs valid
//  out_ready   in   1   consumer accepts result
//  diff_out    out  W   (a - b - bin) mod 2^W
//  borrow_out  out  1   1 iff a < b + bin, operands taken as unsigned
//  ovf_out     out  1   two's-complement overflow of a - b - bin
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE; in_ready=1 after that edge; out_valid=0,
//    diff_out=0, borrow_out=0, ovf_out=0; any operation in flight is discarded.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready: capture a_in, b_in; carry<=~bin_in; idx<=0; go RUN.
//  - RUN: in_ready=0. Each cycle the core adds a[idx] + ~b[idx] + carry; the sum nibble is
//    written to diff[idx] and carry<=core cout. When idx == NIBBLES-1, latch
//    borrow = ~cout and ovf = (a[W-1] != b[W-1]) & (sum[3] != a[W-1]), then go DONE;
//    otherwise idx<=idx+1.
//  - DONE: out_valid=1; diff_out/borrow_out/ovf_out are stable. in_ready=0. On out_ready:
//    go IDLE, clear out_valid. Outputs keep their last values until the next result.
//  - Latency: the handshake edge is E0; out_valid rises after edge E(NIBBLES). Throughput:
//    one operation per NIBBLES+2 cycles when out_ready is held high. No overlap of operations.
//  - in_valid during RUN/DONE is ignored (in_ready=0); the source must hold its operands.
//  - out_ready while out_valid=0 has no effect.
//  - rst takes priority over every handshake on the same edge.
//  - NIBBLES=1: RUN lasts exactly one cycle; idx is a 1-bit signal held at 0.
// STRUCTURE
//  - Shared package ks_pkg: NIBBLE_W=4 and the state enum {IDLE,RUN,DONE}.
//  - Sub-module: the existing kogge_stone_4bit core (a, b, cin -> sum, cout), instanced once
//    with b = ~b_nibble. Operand, diff and carry registers and the FSM are local to this block.
// TESTING (NIBBLES=4 unless stated)
//  1. a=0x1234 b=0x0234 bin=0 -> diff=0x1000 borrow=0 ovf=0; out_valid 4 cycles after the
//     handshake cycle.
//  2. a=0x0000 b=0x0001 bin=0 -> diff=0xFFFF borrow=1 ovf=0 (borrow ripples across all nibbles).
//  3. a=0x8000 b=0x0001 bin=0 -> diff=0x7FFF borrow=0 ovf=1. a=0x7FFF b=0xFFFF -> diff=0x8000
//     borrow=1 ovf=1.
//  4. a=0x0005 b=0x0005 bin=1 -> diff=0xFFFF borrow=1. Back-to-back operations with
//     out_ready=1 -> in_ready high 1 cycle after each result is accepted.
//  5. Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid and diff stay stable and
//     in_ready stays 0; out_ready=1 -> IDLE on the next edge.
//  6. rst=1 on the 2nd RUN cycle -> IDLE, out_valid=0, outputs 0. A following a=0x00FF
//     b=0x000F -> diff=0x00F0. Repeat cases 1-2 with NIBBLES=1 (a=4 b=2 -> diff=2; 0-1 -> F,
//     borrow=1).

Source files
------------

// File: rtl/ks_pkg.sv
// Shared definitions for the Kogge-Stone arithmetic blocks.
package ks_pkg;

    // Width of one slice handled by the 4-bit Kogge-Stone core.
    localparam int NIBBLE_W = 4;

    // Sequencing states of the serial subtractor.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a nibble index; kept at least 1 bit so NIBBLES=1 still has a signal.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/kogge_stone_4bit.sv
// 4-bit Kogge-Stone adder core: sum = a + b + cin, cout = carry out of bit 3.
// The carry-in is folded in as prefix position 0 (generate = cin, propagate = 0),
// so every carry falls out of the same log-depth prefix tree.
module kogge_stone_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // Bit-level generate/propagate for operand positions 1..4 (position 0 is cin).
    logic [3:0] g0;
    logic [3:0] p0;

    // Level 1 (distance 1)
    logic g1_1, g1_2, g1_3, g1_4;
    logic p1_2, p1_3, p1_4;

    // Level 2 (distance 2)
    logic g2_2, g2_3, g2_4;
    logic p2_4;

    // Level 3 (distance 4)
    logic g3_4;

    assign g0 = a & b;
    assign p0 = a ^ b;

    // Level 1: combine each position with its neighbour one below.
    assign g1_1 = g0[0] | (p0[0] & cin);
    assign g1_2 = g0[1] | (p0[1] & g0[0]);
    assign p1_2 = p0[1] & p0[0];
    assign g1_3 = g0[2] | (p0[2] & g0[1]);
    assign p1_3 = p0[2] & p0[1];
    assign g1_4 = g0[3] | (p0[3] & g0[2]);
    assign p1_4 = p0[3] & p0[2];

    // Level 2: combine with the group two positions below.
    assign g2_2 = g1_2 | (p1_2 & cin);
    assign g2_3 = g1_3 | (p1_3 & g1_1);
    assign g2_4 = g1_4 | (p1_4 & g1_2);
    assign p2_4 = p1_4 & p1_2;

    // Level 3: only the carry-out position still lacks cin.
    assign g3_4 = g2_4 | (p2_4 & cin);

    // Carry into bit i is the prefix generate over cin..bit i-1.
    assign sum[0] = p0[0] ^ cin;
    assign sum[1] = p0[1] ^ g1_1;
    assign sum[2] = p0[2] ^ g2_2;
    assign sum[3] = p0[3] ^ g2_3;
    assign cout   = g3_4;

endmodule

// File: rtl/ks_serial_subtractor.sv
// Serial subtractor: diff = a - b - bin, one nibble per cycle through a single
// 4-bit Kogge-Stone core. Subtraction is done as a + ~b + ~bin with the carry
// registered between nibbles; the final borrow is the inverted carry-out.
module ks_serial_subtractor
    import ks_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         bin_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff_out,
    output logic         borrow_out,
    output logic         ovf_out
);

    localparam int                IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e state_q, state_d;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     diff_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             borrow_q;
    logic             ovf_q;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] b_inv;
    logic [NIBBLE_W-1:0] sum_nib;
    logic                cout;
    logic                last_nib;

    assign last_nib = (idx_q == LAST_IDX);
    assign b_inv    = ~b_nib;

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    kogge_stone_4bit u_core (
        .a    (a_nib),
        .b    (b_inv),
        .cin  (carry_q),
        .sum  (sum_nib),
        .cout (cout)
    );

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: accept operands, walk the nibbles, hold the result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath: capture operands, accumulate diff nibbles, latch the final flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= ~bin_in;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_q == IDX_W'(i)) diff_q[i*NIBBLE_W +: NIBBLE_W] <= sum_nib;
                    end
                    carry_q <= cout;
                    if (last_nib) begin
                        borrow_q <= ~cout;
                        // Overflow only when operand signs differ and the result sign leaves a's.
                        ovf_q    <= (a_q[W-1] != b_q[W-1]) & (sum_nib[NIBBLE_W-1] != a_q[W-1]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;
    assign ovf_out    = ovf_q;

endmodule
